// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: default field widths, opcode constants and
// the A-request / D-response bundles used by the arbiter and its bench.
package tl_ul_pkg;

    localparam int TL_ADDR_W = 32;
    localparam int TL_DATA_W = 32;
    localparam int TL_SRC_W  = 2;
    localparam int TL_SIZE_W = 2;
    localparam int TL_MASK_W = TL_DATA_W / 8;

    localparam logic [2:0] A_GET        = 3'd4;
    localparam logic [2:0] A_PUTFULL    = 3'd0;
    localparam logic [2:0] A_PUTPARTIAL = 3'd1;
    localparam logic [2:0] D_ACK        = 3'd0;
    localparam logic [2:0] D_ACKDATA    = 3'd1;

    // Source is the downstream width: {master index, upstream source}.
    typedef struct packed {
        logic [2:0]           opcode;
        logic [2:0]           param;
        logic [TL_SIZE_W-1:0] size;
        logic [TL_SRC_W:0]    source;
        logic [TL_ADDR_W-1:0] address;
        logic [TL_MASK_W-1:0] mask;
        logic [TL_DATA_W-1:0] data;
    } tl_a_req_t;

    typedef struct packed {
        logic [2:0]           opcode;
        logic [TL_SIZE_W-1:0] size;
        logic [TL_SRC_W:0]    source;
        logic [TL_DATA_W-1:0] data;
        logic                 denied;
    } tl_d_rsp_t;

endpackage

// File: rtl/tl_outstanding_ctr.sv
// Per-master outstanding-request counter: up on A handshake, down on D
// handshake, never wraps; flags full and responses that arrive with nothing owed.
module tl_outstanding_ctr #(
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic full_o,
    output logic stray_o
);

    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_OUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        // NOTE: default assignment first, so no branch leaves cnt_d unassigned and infers a latch.
        cnt_d = cnt_q;
        if (inc_i && !dec_i && cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end else if (dec_i && !inc_i && cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign full_o  = (cnt_q >= MaxCnt);
    assign stray_o = dec_i && (cnt_q == '0);

endmodule

// File: rtl/tl_ul_arb2.sv
// Two-master TileLink-UL arbiter: round-robin A grant into a registered output
// slot, D responses routed back combinationally by the inserted source MSB.
module tl_ul_arb2
    import tl_ul_pkg::*;
#(
    parameter int ADDR_W  = TL_ADDR_W,
    parameter int DATA_W  = TL_DATA_W,
    parameter int SRC_W   = TL_SRC_W,
    parameter int SIZE_W  = TL_SIZE_W,
    parameter int MAX_OUT = 4
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                m0_a_valid,
    output logic                m0_a_ready,
    input  logic [2:0]          m0_a_opcode,
    input  logic [2:0]          m0_a_param,
    input  logic [SIZE_W-1:0]   m0_a_size,
    input  logic [SRC_W-1:0]    m0_a_source,
    input  logic [ADDR_W-1:0]   m0_a_address,
    input  logic [DATA_W/8-1:0] m0_a_mask,
    input  logic [DATA_W-1:0]   m0_a_data,
    output logic                m0_d_valid,
    input  logic                m0_d_ready,
    output logic [2:0]          m0_d_opcode,
    output logic [SIZE_W-1:0]   m0_d_size,
    output logic [SRC_W-1:0]    m0_d_source,
    output logic [DATA_W-1:0]   m0_d_data,
    output logic                m0_d_denied,

    input  logic                m1_a_valid,
    output logic                m1_a_ready,
    input  logic [2:0]          m1_a_opcode,
    input  logic [2:0]          m1_a_param,
    input  logic [SIZE_W-1:0]   m1_a_size,
    input  logic [SRC_W-1:0]    m1_a_source,
    input  logic [ADDR_W-1:0]   m1_a_address,
    input  logic [DATA_W/8-1:0] m1_a_mask,
    input  logic [DATA_W-1:0]   m1_a_data,
    output logic                m1_d_valid,
    input  logic                m1_d_ready,
    output logic [2:0]          m1_d_opcode,
    output logic [SIZE_W-1:0]   m1_d_size,
    output logic [SRC_W-1:0]    m1_d_source,
    output logic [DATA_W-1:0]   m1_d_data,
    output logic                m1_d_denied,

    output logic                out_a_valid,
    input  logic                out_a_ready,
    output logic [2:0]          out_a_opcode,
    output logic [2:0]          out_a_param,
    output logic [SIZE_W-1:0]   out_a_size,
    output logic [SRC_W:0]      out_a_source,
    output logic [ADDR_W-1:0]   out_a_address,
    output logic [DATA_W/8-1:0] out_a_mask,
    output logic [DATA_W-1:0]   out_a_data,

    input  logic                out_d_valid,
    output logic                out_d_ready,
    input  logic [2:0]          out_d_opcode,
    input  logic [SIZE_W-1:0]   out_d_size,
    input  logic [SRC_W:0]      out_d_source,
    input  logic [DATA_W-1:0]   out_d_data,
    input  logic                out_d_denied,

    output logic                err_stray
);

    logic full0, full1, stray0, stray1;
    logic elig0, elig1, slot_free, gnt0, gnt1;
    logic sel, d_hs0, d_hs1;

    tl_a_req_t req_q, req_d;
    logic      a_valid_q, a_valid_d;
    logic      rr_q, rr_d;
    logic      err_q, err_d;

    // Eligibility uses the registered count, so a same-cycle D cannot unblock a full master.
    assign elig0     = m0_a_valid && !full0;
    assign elig1     = m1_a_valid && !full1;
    assign slot_free = !a_valid_q || out_a_ready;
    assign gnt0      = slot_free && elig0 && (!elig1 || !rr_q);
    assign gnt1      = slot_free && elig1 && (!elig0 || rr_q);

    assign m0_a_ready = gnt0;
    assign m1_a_ready = gnt1;

    always_comb begin
        req_d     = req_q;
        a_valid_d = a_valid_q;
        rr_d      = rr_q;
        if (gnt0) begin
            req_d.opcode  = m0_a_opcode;
            req_d.param   = m0_a_param;
            req_d.size    = m0_a_size;
            req_d.source  = {1'b0, m0_a_source};
            req_d.address = m0_a_address;
            req_d.mask    = m0_a_mask;
            req_d.data    = m0_a_data;
            a_valid_d     = 1'b1;
            rr_d          = 1'b1;
        end else if (gnt1) begin
            req_d.opcode  = m1_a_opcode;
            req_d.param   = m1_a_param;
            req_d.size    = m1_a_size;
            req_d.source  = {1'b1, m1_a_source};
            req_d.address = m1_a_address;
            req_d.mask    = m1_a_mask;
            req_d.data    = m1_a_data;
            a_valid_d     = 1'b1;
            rr_d          = 1'b0;
        end else if (slot_free) begin
            a_valid_d = 1'b0;
        end
    end

    assign err_d = err_q || stray0 || stray1;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            req_q     <= '0;
            a_valid_q <= 1'b0;
            rr_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            req_q     <= req_d;
            a_valid_q <= a_valid_d;
            rr_q      <= rr_d;
            err_q     <= err_d;
        end
    end

    assign out_a_valid   = a_valid_q;
    assign out_a_opcode  = req_q.opcode;
    assign out_a_param   = req_q.param;
    assign out_a_size    = req_q.size;
    assign out_a_source  = req_q.source;
    assign out_a_address = req_q.address;
    assign out_a_mask    = req_q.mask;
    assign out_a_data    = req_q.data;
    assign err_stray     = err_q;

    // D path: the MSB inserted on the A side selects the master; fields are broadcast.
    assign sel         = out_d_source[SRC_W];
    assign m0_d_valid  = out_d_valid && !sel;
    assign m1_d_valid  = out_d_valid && sel;
    assign out_d_ready = sel ? m1_d_ready : m0_d_ready;
    assign d_hs0       = out_d_valid && !sel && m0_d_ready;
    assign d_hs1       = out_d_valid && sel && m1_d_ready;

    assign m0_d_opcode = out_d_opcode;
    assign m0_d_size   = out_d_size;
    assign m0_d_source = out_d_source[SRC_W-1:0];
    assign m0_d_data   = out_d_data;
    assign m0_d_denied = out_d_denied;
    assign m1_d_opcode = out_d_opcode;
    assign m1_d_size   = out_d_size;
    assign m1_d_source = out_d_source[SRC_W-1:0];
    assign m1_d_data   = out_d_data;
    assign m1_d_denied = out_d_denied;

    tl_outstanding_ctr #(.MAX_OUT(MAX_OUT), .CNT_W(4)) u_ctr0 (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (gnt0),
        .dec_i   (d_hs0),
        .full_o  (full0),
        .stray_o (stray0)
    );

    tl_outstanding_ctr #(.MAX_OUT(MAX_OUT), .CNT_W(4)) u_ctr1 (
        .clock   (clock),
        .reset_n (reset_n),
        .inc_i   (gnt1),
        .dec_i   (d_hs1),
        .full_o  (full1),
        .stray_o (stray1)
    );

endmodule

// File: tb/tb_tl_ul_arb2.sv
// Bench for tl_ul_arb2: routing/grant vector table, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_tl_ul_arb2;
    import tl_ul_pkg::*;

    localparam int MAXO = 4;

    logic clock = 1'b0;
    logic reset_n = 1'b0;

    logic        a_valid[2];
    logic        a_ready[2];
    logic [2:0]  a_opcode[2];
    logic [2:0]  a_param[2];
    logic [1:0]  a_size[2];
    logic [1:0]  a_source[2];
    logic [31:0] a_address[2];
    logic [3:0]  a_mask[2];
    logic [31:0] a_data[2];
    logic        d_valid[2];
    logic        d_ready[2];
    logic [2:0]  md_opcode[2];
    logic [1:0]  md_size[2];
    logic [1:0]  md_source[2];
    logic [31:0] md_data[2];
    logic        md_denied[2];

    logic        oa_valid, oa_ready;
    logic [2:0]  oa_opcode, oa_param;
    logic [1:0]  oa_size;
    logic [2:0]  oa_source;
    logic [31:0] oa_address;
    logic [3:0]  oa_mask;
    logic [31:0] oa_data;
    logic        od_valid, od_ready;
    logic [2:0]  od_opcode;
    logic [1:0]  od_size;
    logic [2:0]  od_source;
    logic [31:0] od_data;
    logic        od_denied;
    logic        err_stray;

    int checks = 0;
    int errors = 0;

    tl_ul_arb2 #(.ADDR_W(32), .DATA_W(32), .SRC_W(2), .SIZE_W(2), .MAX_OUT(MAXO)) dut (
        .clock(clock), .reset_n(reset_n),
        .m0_a_valid(a_valid[0]), .m0_a_ready(a_ready[0]), .m0_a_opcode(a_opcode[0]),
        .m0_a_param(a_param[0]), .m0_a_size(a_size[0]), .m0_a_source(a_source[0]),
        .m0_a_address(a_address[0]), .m0_a_mask(a_mask[0]), .m0_a_data(a_data[0]),
        .m0_d_valid(d_valid[0]), .m0_d_ready(d_ready[0]), .m0_d_opcode(md_opcode[0]),
        .m0_d_size(md_size[0]), .m0_d_source(md_source[0]), .m0_d_data(md_data[0]),
        .m0_d_denied(md_denied[0]),
        .m1_a_valid(a_valid[1]), .m1_a_ready(a_ready[1]), .m1_a_opcode(a_opcode[1]),
        .m1_a_param(a_param[1]), .m1_a_size(a_size[1]), .m1_a_source(a_source[1]),
        .m1_a_address(a_address[1]), .m1_a_mask(a_mask[1]), .m1_a_data(a_data[1]),
        .m1_d_valid(d_valid[1]), .m1_d_ready(d_ready[1]), .m1_d_opcode(md_opcode[1]),
        .m1_d_size(md_size[1]), .m1_d_source(md_source[1]), .m1_d_data(md_data[1]),
        .m1_d_denied(md_denied[1]),
        .out_a_valid(oa_valid), .out_a_ready(oa_ready), .out_a_opcode(oa_opcode),
        .out_a_param(oa_param), .out_a_size(oa_size), .out_a_source(oa_source),
        .out_a_address(oa_address), .out_a_mask(oa_mask), .out_a_data(oa_data),
        .out_d_valid(od_valid), .out_d_ready(od_ready), .out_d_opcode(od_opcode),
        .out_d_size(od_size), .out_d_source(od_source), .out_d_data(od_data),
        .out_d_denied(od_denied),
        .err_stray(err_stray)
    );

    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        for (int n = 0; n < 2; n++) begin
            a_valid[n]   = 1'b0;
            a_opcode[n]  = '0;
            a_param[n]   = '0;
            a_size[n]    = '0;
            a_source[n]  = '0;
            a_address[n] = '0;
            a_mask[n]    = '0;
            a_data[n]    = '0;
            d_ready[n]   = 1'b1;
        end
        oa_ready  = 1'b1;
        od_valid  = 1'b0;
        od_opcode = '0;
        od_size   = '0;
        od_source = '0;
        od_data   = '0;
        od_denied = 1'b0;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    typedef struct {
        logic       a0, a1, dv;
        logic [2:0] dsrc;
        logic       r0, r1;
        logic       g0, g1, dv0, dv1, dr;
    } vec_t;

    vec_t tbl[6];

    // Reference-model state (transaction level).
    bit          pv;
    logic [2:0]  p_src, p_op;
    logic [31:0] p_addr, p_data;
    int          ptr;
    int          cnt[2];
    bit          err;

    initial begin
        logic [2:0] ops[3];
        idle();

        // Reset values while reset is held.
        reset_n = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst out_a_valid", oa_valid, 0);
        check("rst out_a_source", oa_source, 0);
        check("rst out_a_address", oa_address, 0);
        check("rst out_a_data", oa_data, 0);
        check("rst err_stray", err_stray, 0);
        reset_n = 1'b1;

        // Combinational grant/routing vectors from the reset state (ptr=0, counts 0, slot empty).
        tbl[0] = '{1'b1, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 3'b110, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 3'b011, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 1'b1, 3'b101, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 3'b100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            a_valid[0] = tbl[i].a0;
            a_valid[1] = tbl[i].a1;
            od_valid   = tbl[i].dv;
            od_source  = tbl[i].dsrc;
            d_ready[0] = tbl[i].r0;
            d_ready[1] = tbl[i].r1;
            #1;
            check("tbl m0_a_ready", a_ready[0], tbl[i].g0);
            check("tbl m1_a_ready", a_ready[1], tbl[i].g1);
            check("tbl m0_d_valid", d_valid[0], tbl[i].dv0);
            check("tbl m1_d_valid", d_valid[1], tbl[i].dv1);
            check("tbl out_d_ready", od_ready, tbl[i].dr);
            check("tbl m1_d_source", md_source[1], tbl[i].dsrc[1:0]);
            idle();
        end

        // Single master Get and its response.
        do_reset();
        a_valid[0] = 1'b1; a_opcode[0] = A_GET; a_address[0] = 32'h8000_0000; a_source[0] = 2'd1;
        #1;
        check("single m0_a_ready", a_ready[0], 1);
        tick();
        idle();
        check("single out_a_valid", oa_valid, 1);
        check("single out_a_source", oa_source, 3'b001);
        check("single out_a_address", oa_address, 32'h8000_0000);
        check("single out_a_opcode", oa_opcode, A_GET);
        od_valid = 1'b1; od_source = 3'b001; od_data = 32'hDEAD_BEEF; od_opcode = D_ACKDATA;
        #1;
        check("single m0_d_valid", d_valid[0], 1);
        check("single m1_d_valid", d_valid[1], 0);
        check("single m0_d_source", md_source[0], 1);
        check("single m0_d_data", md_data[0], 32'hDEAD_BEEF);
        check("single out_d_ready", od_ready, 1);
        tick();
        idle();
        check("single slot drained", oa_valid, 0);
        check("single no stray", err_stray, 0);

        // Contention: both masters always valid, grants alternate with no bubbles.
        do_reset();
        a_valid[0] = 1'b1; a_source[0] = 2'd0;
        a_valid[1] = 1'b1; a_source[1] = 2'd2;
        for (int i = 0; i < 6; i++) begin
            #1;
            check("rr m0_a_ready", a_ready[0], (i % 2) == 0);
            check("rr m1_a_ready", a_ready[1], (i % 2) == 1);
            tick();
            check("rr out_a_valid", oa_valid, 1);
            check("rr out_a_source", oa_source, (i % 2) ? 3'b110 : 3'b000);
        end
        idle();

        // Throttle: m1 fills to MAX_OUT, one response reopens it a cycle later.
        do_reset();
        a_valid[1] = 1'b1; a_opcode[1] = A_GET; a_source[1] = 2'd1;
        for (int i = 0; i < MAXO; i++) begin
            #1;
            check("thr grant", a_ready[1], 1);
            tick();
        end
        #1;
        check("thr full blocks", a_ready[1], 0);
        od_valid = 1'b1; od_source = 3'b101; d_ready[1] = 1'b1;
        #1;
        check("thr same-cycle D", a_ready[1], 0);
        check("thr m1_d_valid", d_valid[1], 1);
        tick();
        od_valid = 1'b0;
        #1;
        check("thr resumed", a_ready[1], 1);
        tick();
        idle();

        // Backpressure: slot held for 3 cycles, queued m1 granted on release.
        do_reset();
        oa_ready = 1'b0;
        a_valid[0] = 1'b1; a_opcode[0] = A_PUTFULL; a_data[0] = 32'h1234_5678;
        a_source[0] = 2'd2; a_address[0] = 32'h100; a_mask[0] = 4'hF;
        #1;
        check("bp first grant", a_ready[0], 1);
        tick();
        a_valid[0] = 1'b0;
        a_valid[1] = 1'b1; a_opcode[1] = A_GET; a_source[1] = 2'd3; a_address[1] = 32'h200;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp no grant", a_ready[1], 0);
            check("bp data stable", oa_data, 32'h1234_5678);
            check("bp opcode stable", oa_opcode, A_PUTFULL);
            check("bp source stable", oa_source, 3'b010);
            check("bp valid held", oa_valid, 1);
            tick();
        end
        oa_ready = 1'b1;
        #1;
        check("bp release grant", a_ready[1], 1);
        tick();
        check("bp m1 source", oa_source, 3'b111);
        check("bp m1 address", oa_address, 32'h200);
        idle();

        // Stray response to m1: forwarded, sticky error, counter stays at zero.
        do_reset();
        od_valid = 1'b1; od_source = 3'b100; d_ready[1] = 1'b1;
        #1;
        check("stray m1_d_valid", d_valid[1], 1);
        check("stray out_d_ready", od_ready, 1);
        check("stray err before edge", err_stray, 0);
        tick();
        idle();
        check("stray err set", err_stray, 1);
        tick();
        check("stray err sticky", err_stray, 1);
        a_valid[1] = 1'b1;
        for (int i = 0; i <= MAXO; i++) begin
            #1;
            check("stray cnt from zero", a_ready[1], i < MAXO);
            tick();
        end
        idle();

        // Asynchronous reset mid-transaction.
        do_reset();
        a_valid[0] = 1'b1; a_address[0] = 32'hABCD_0000; a_source[0] = 2'd1;
        tick();
        tick();
        a_valid[0] = 1'b0;
        check("areset pre valid", oa_valid, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset out_a_valid", oa_valid, 0);
        check("areset out_a_address", oa_address, 0);
        check("areset out_a_source", oa_source, 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        a_valid[0] = 1'b1; a_valid[1] = 1'b1;
        #1;
        check("areset m0 preferred", a_ready[0], 1);
        check("areset m1 waits", a_ready[1], 0);
        a_valid[0] = 1'b0; a_valid[1] = 1'b0;
        od_valid = 1'b1; od_source = 3'b001; d_ready[0] = 1'b1;
        #1;
        check("areset late D routed", d_valid[0], 1);
        tick();
        idle();
        check("areset late D is stray", err_stray, 1);

        // Randomized traffic against the reference model.
        do_reset();
        ops[0] = A_GET; ops[1] = A_PUTFULL; ops[2] = A_PUTPARTIAL;
        pv = 0; ptr = 0; cnt[0] = 0; cnt[1] = 0; err = 0;
        p_src = '0; p_op = '0; p_addr = '0; p_data = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            int  g;
            int  tgt;
            int  sel;
            bit  slot_free, dhs;
            bit  e[2];
            for (int n = 0; n < 2; n++) begin
                a_valid[n]   = ($urandom_range(0, 3) != 0);
                a_opcode[n]  = ops[$urandom_range(0, 2)];
                a_param[n]   = 3'($urandom);
                a_size[n]    = 2'($urandom);
                a_source[n]  = 2'($urandom);
                a_address[n] = $urandom;
                a_mask[n]    = 4'($urandom);
                a_data[n]    = $urandom;
                d_ready[n]   = ($urandom_range(0, 3) != 0);
            end
            oa_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 19) == 0) tgt = $urandom_range(0, 1);
            else if (cnt[0] > 0 && cnt[1] > 0) tgt = $urandom_range(0, 1);
            else tgt = (cnt[1] > 0) ? 1 : 0;
            od_valid  = ($urandom_range(0, 1) == 1);
            od_source = {tgt[0], 2'($urandom)};
            od_data   = $urandom;
            od_opcode = ($urandom_range(0, 1) == 1) ? D_ACKDATA : D_ACK;
            od_size   = 2'($urandom);
            od_denied = ($urandom_range(0, 7) == 0);
            #1;

            slot_free = !pv || oa_ready;
            for (int n = 0; n < 2; n++) e[n] = a_valid[n] && (cnt[n] < MAXO);
            g = -1;
            if (slot_free) begin
                if (e[0] && e[1]) g = ptr;
                else if (e[0]) g = 0;
                else if (e[1]) g = 1;
            end
            sel = od_source[2];
            dhs = od_valid && d_ready[sel];

            check("rnd m0_a_ready", a_ready[0], g == 0);
            check("rnd m1_a_ready", a_ready[1], g == 1);
            check("rnd m0_d_valid", d_valid[0], od_valid && sel == 0);
            check("rnd m1_d_valid", d_valid[1], od_valid && sel == 1);
            check("rnd out_d_ready", od_ready, d_ready[sel]);
            check("rnd m0_d_data", md_data[0], od_data);
            check("rnd m1_d_denied", md_denied[1], od_denied);
            check("rnd m0_d_source", md_source[0], od_source[1:0]);

            tick();

            if (g >= 0) begin
                pv     = 1;
                p_src  = {g[0], a_source[g]};
                p_op   = a_opcode[g];
                p_addr = a_address[g];
                p_data = a_data[g];
                ptr    = 1 - g;
            end else if (slot_free) begin
                pv = 0;
            end
            for (int n = 0; n < 2; n++) begin
                bit inc, dec;
                inc = (g == n);
                dec = dhs && (sel == n);
                if (dec && cnt[n] == 0) err = 1;
                if (inc && !dec) cnt[n]++;
                else if (dec && !inc && cnt[n] > 0) cnt[n]--;
            end

            check("rnd out_a_valid", oa_valid, pv);
            if (pv) begin
                check("rnd out_a_source", oa_source, p_src);
                check("rnd out_a_opcode", oa_opcode, p_op);
                check("rnd out_a_address", oa_address, p_addr);
                check("rnd out_a_data", oa_data, p_data);
            end
            check("rnd err_stray", err_stray, err);
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tl_ul_arb2.md
Name: tl_ul_arb2

Overview:
- Two-master to one-slave TileLink-UL arbiter for the memory-port path watched by the TL protocol monitors.
- Shares one downstream A/D channel pair between master 0 (instruction side) and master 1 (data side).
- A channel: round-robin grant into a one-entry registered output stage.
- D channel: routed back combinationally using the source-ID MSB the arbiter inserts. Per-master outstanding counters throttle each master and detect stray responses.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; mask width is DATA_W/8.
- SRC_W, 2, upstream source-ID width; downstream source width is SRC_W+1.
- SIZE_W, 2, lg2 transfer-size field width.
- MAX_OUT, 4, maximum outstanding A requests per master, 1..15.

Ports:
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- mN_a_valid  in  1  master N request valid (N=0,1).
- mN_a_ready  out  1  master N request accepted.
- mN_a_opcode  in  3  TL opcode (Get=4, PutFull=0, PutPartial=1).
- mN_a_param  in  3  TL param.
- mN_a_size  in  SIZE_W  lg2 bytes.
- mN_a_source  in  SRC_W  source ID.
- mN_a_address  in  ADDR_W  byte address.
- mN_a_mask  in  DATA_W/8  byte lanes.
- mN_a_data  in  DATA_W  write data.
- mN_d_valid  out  1  response valid to master N.
- mN_d_ready  in  1  master N accepts response.
- mN_d_opcode  out  3  AccessAck=0 / AccessAckData=1.
- mN_d_size  out  SIZE_W  echoed size.
- mN_d_source  out  SRC_W  source ID with the routing bit stripped.
- mN_d_data  out  DATA_W  read data.
- mN_d_denied  out  1  denied/error flag.
- out_a_valid  out  1  downstream request valid.
- out_a_ready  in  1  downstream request accepted.
- out_a_opcode, out_a_param, out_a_size, out_a_address, out_a_mask, out_a_data  out  same widths as the master A fields  registered copy of the granted request.
- out_a_source  out  SRC_W+1  {master index, upstream source}.
- out_d_valid  in  1  downstream response valid.
- out_d_ready  out  1  downstream response accepted.
- out_d_opcode, out_d_size, out_d_data, out_d_denied  in  same widths as the master D fields  response fields.
- out_d_source  in  SRC_W+1  response source ID.
- err_stray  out  1  sticky error: D response for a master with zero outstanding.

Behaviour:
- Reset (asynchronous assert, synchronous release): out_a_valid=0; all out_a fields=0; both counters=0; round-robin pointer=0 (master 0 preferred); err_stray=0.
- Eligibility: master N is eligible when mN_a_valid=1 and cnt_N<MAX_OUT.
- Slot free: out_a_valid=0, or out_a_valid=1 and out_a_ready=1 in the same cycle (back-to-back allowed).
- Grant (combinational): only when the slot is free.
  - Exactly one master eligible: grant it.
  - Both eligible: grant the master named by the pointer.
  - mN_a_ready = grant_N. Never assert both.
- On grant:
  - The next edge loads the output register with the granted fields and source {N, mN_a_source}; out_a_valid=1.
  - The pointer moves to the other master.
  - Latency is one cycle from master handshake to out_a_valid.
- Slot freed with no grant: out_a_valid clears.
- Stall: while out_a_valid=1 and out_a_ready=0, all out_a fields hold stable.
- D routing (zero latency):
  - sel = out_d_source[SRC_W].
  - m_sel_d_valid = out_d_valid; the other master's d_valid=0.
  - out_d_ready = m_sel_d_ready.
  - D fields are broadcast to both masters; mN_d_source = out_d_source[SRC_W-1:0].
- Counters:
  - cnt_N increments on a master N A handshake.
  - cnt_N decrements on a D handshake routed to master N.
  - Both in one cycle: cnt_N is unchanged.
  - Counter width is 4 bits; MAX_OUT ≤ 15 prevents overflow.
- Stray response: a D handshake to master N with cnt_N=0 sets err_stray (cleared only by reset). The counter does not underflow; it stays 0. The response is still forwarded.
- Full: cnt_N=MAX_OUT makes master N ineligible. A same-cycle D decrement does not restore eligibility until the next cycle (eligibility uses the registered count).
- Reset mid-transaction: all in-flight state is discarded. Responses arriving later count as stray.

Decomposition:
- Shared package tl_ul_pkg holds:
  - opcode constants: A_GET=4, A_PUTFULL=0, A_PUTPARTIAL=1, D_ACK=0, D_ACKDATA=1;
  - a packed struct tl_a_req_t {opcode, param, size, source, address, mask, data};
  - tl_d_rsp_t.
- One sub-module, tl_outstanding_ctr: saturating up/down counter with full and stray-detect outputs. It is instantiated once per master.

Test Plan:
- Single master: m0 Get addr 0x8000_0000 src 1 → out_a_valid next cycle with out_a_source=3'b001. Response out_d_source=3'b001 data 0xDEAD_BEEF → m0_d_valid=1, m0_d_source=1.
- Contention: both masters hold valid every cycle, out_a_ready=1 → grants alternate m0, m1, m0, m1. out_a_source MSB toggles each cycle with no bubbles.
- Throttle: m1 issues 4 Gets with D withheld → m1_a_ready=0 on the 5th. One D to m1 → grant resumes the following cycle.
- Backpressure: out_a_ready=0 for 3 cycles with PutFull data 0x1234_5678 → fields stable, no new grant. Release → the queued master is granted the same cycle.
- Stray: out_d_valid with source 3'b100 while cnt1=0 → err_stray=1 stays set, cnt1 stays 0, m1_d_valid=1.
- Async reset asserted with cnt0=2 and out_a_valid=1 → outputs clear immediately without a clock edge. After release, m0 is preferred first.
